// File: rtl/freq_ctrl_pkg.sv
// Shared types and constant helpers for the multi-channel frequency controller.
package freq_ctrl_pkg;

    // Button auto-repeat states.
    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_HOLD   = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    // Width of the scale index port; covers up to 8 decade scales.
    localparam int SCALE_W = 3;

    // Step size for a decade scale: 10^scale.
    function automatic logic [31:0] step_of(input logic [SCALE_W-1:0] scale);
        logic [31:0] s;
        s = 32'd1;
        for (int i = 0; i < 7; i++) begin
            if (i < int'(scale)) s = s * 32'd10;
        end
        return s;
    endfunction

    // Bits needed to hold every value in 0..max_val.
    function automatic int width_of(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/frequency_control_mc_button_repeat.sv
// Press detection and hold-to-repeat timing for the up/down buttons.
// step_req is combinational so a step lands on the same edge that samples it.
module button_repeat
    import freq_ctrl_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY  = 25_000_000,
    parameter int unsigned REPEAT_PERIOD = 5_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic up_level,
    input  logic down_level,
    input  logic force_idle,
    output logic step_req,
    output logic step_dir
);

    localparam logic [31:0] DLY_LAST = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] PER_LAST = 32'(REPEAT_PERIOD - 1);

    rpt_state_e  state_q;
    logic [31:0] cnt_q;
    logic        dir_q;
    logic        up_prev_q;
    logic        down_prev_q;

    logic dir_up;
    logic dir_dn;
    logic press;
    logic held_same;

    // Decode the button levels and decide whether this cycle issues a step.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        dir_up    = up_level & ~down_level;
        dir_dn    = down_level & ~up_level;
        press     = (dir_up | dir_dn) & ~(up_prev_q | down_prev_q);
        held_same = dir_q ? dir_up : dir_dn;
        step_req  = 1'b0;
        step_dir  = dir_up;
        case (state_q)
            RPT_IDLE: begin
                step_req = press;
                step_dir = dir_up;
            end
            RPT_HOLD: begin
                step_req = held_same && (cnt_q == DLY_LAST);
                step_dir = dir_q;
            end
            RPT_REPEAT: begin
                step_req = held_same && (cnt_q == PER_LAST);
                step_dir = dir_q;
            end
            default: begin
                step_req = 1'b0;
                step_dir = dir_up;
            end
        endcase
    end

    // Repeat FSM, hold counter and the one-cycle-delayed button levels.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q     <= RPT_IDLE;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            up_prev_q   <= 1'b0;
            down_prev_q <= 1'b0;
        end else begin
            up_prev_q   <= up_level;
            down_prev_q <= down_level;
            if (force_idle) begin
                state_q <= RPT_IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    RPT_IDLE: begin
                        if (press) begin
                            state_q <= RPT_HOLD;
                            cnt_q   <= '0;
                            dir_q   <= dir_up;
                        end
                    end
                    RPT_HOLD: begin
                        if (!held_same) begin
                            state_q <= RPT_IDLE;
                        end else if (cnt_q == DLY_LAST) begin
                            state_q <= RPT_REPEAT;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 32'd1;
                        end
                    end
                    RPT_REPEAT: begin
                        if (!held_same) begin
                            state_q <= RPT_IDLE;
                        end else if (cnt_q == PER_LAST) begin
                            cnt_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + 32'd1;
                        end
                    end
                    default: state_q <= RPT_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/frequency_control_mc.sv
// Per-channel frequency setpoints with decade up/down steps, saturate or wrap
// at the bounds, and hold-to-repeat. Feeds the NCO/reference generators.
module frequency_control_mc
    import freq_ctrl_pkg::*;
#(
    parameter int          NUM_CH        = 2,
    parameter int          FREQ_MIN      = 0,
    parameter int          FREQ_MAX      = 8191,
    parameter int          NUM_SCALES    = 4,
    parameter int unsigned REPEAT_DELAY  = 25_000_000,
    parameter int unsigned REPEAT_PERIOD = 5_000_000,
    parameter bit          WRAP_EN       = 1'b0,
    localparam int         W             = width_of(FREQ_MAX),
    localparam int         CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  up_level,
    input  logic                  down_level,
    input  logic                  scale_pulse,
    input  logic                  ch_pulse,
    output logic [NUM_CH*W-1:0]   freq_out,
    output logic [CH_W-1:0]       ch_sel_out,
    output logic [SCALE_W-1:0]    scale_out,
    output logic                  update_pulse,
    output logic                  at_limit
);

    // Arithmetic width must hold FREQ_MAX plus the largest step without overflow.
    localparam logic [31:0] STEP_MAX = step_of(SCALE_W'(NUM_SCALES - 1));
    localparam int          AW_MIN   = width_of(FREQ_MAX + int'(STEP_MAX));
    localparam int          AW       = (AW_MIN > W + 1) ? AW_MIN : W + 1;
    localparam logic [AW-1:0] MAX_A  = AW'(FREQ_MAX);
    localparam logic [AW-1:0] MIN_A  = AW'(FREQ_MIN);
    localparam logic [W-1:0]  MAX_W  = W'(FREQ_MAX);
    localparam logic [W-1:0]  MIN_W  = W'(FREQ_MIN);

    logic               step_req;
    logic               step_dir;
    logic [W-1:0]       freq_q [NUM_CH];
    logic [CH_W-1:0]    ch_sel_q;
    logic [SCALE_W-1:0] scale_q;
    logic               update_q;
    logic               at_limit_q;

    logic [AW-1:0]      f_a;
    logic [AW-1:0]      s_a;
    logic [AW-1:0]      sum_a;
    logic [W-1:0]       next_f;
    logic               clamp;

    button_repeat #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_button_repeat (
        .clk        (clk),
        .reset      (reset),
        .up_level   (up_level),
        .down_level (down_level),
        .force_idle (ch_pulse),
        .step_req   (step_req),
        .step_dir   (step_dir)
    );

    // Next value of the selected channel for a step at the current scale.
    always_comb begin
        f_a    = AW'(freq_q[ch_sel_q]);
        s_a    = AW'(step_of(scale_q));
        sum_a  = f_a + s_a;
        next_f = freq_q[ch_sel_q];
        clamp  = 1'b0;
        if (step_dir) begin
            if (sum_a <= MAX_A) begin
                next_f = W'(sum_a);
            end else begin
                next_f = WRAP_EN ? MIN_W : MAX_W;
                clamp  = 1'b1;
            end
        end else begin
            if (f_a >= MIN_A + s_a) begin
                next_f = W'(f_a - s_a);
            end else begin
                next_f = WRAP_EN ? MAX_W : MIN_W;
                clamp  = 1'b1;
            end
        end
    end

    // Setpoint array, selection counters and the registered status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the setpoint array is a small set of flops, not a RAM, so it is reset like any register.
            for (int c = 0; c < NUM_CH; c++) freq_q[c] <= MIN_W;
            ch_sel_q   <= '0;
            scale_q    <= '0;
            update_q   <= 1'b0;
            at_limit_q <= 1'b0;
        end else begin
            update_q <= step_req;
            if (step_req) begin
                freq_q[ch_sel_q] <= next_f;
                at_limit_q       <= clamp;
            end
            if (ch_pulse) begin
                ch_sel_q <= (ch_sel_q == CH_W'(NUM_CH - 1)) ? '0 : ch_sel_q + CH_W'(1);
            end
            if (scale_pulse) begin
                scale_q <= (scale_q == SCALE_W'(NUM_SCALES - 1)) ? '0 : scale_q + SCALE_W'(1);
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_pack
        assign freq_out[c*W +: W] = freq_q[c];
    end

    assign ch_sel_out   = ch_sel_q;
    assign scale_out    = scale_q;
    assign update_pulse = update_q;
    assign at_limit     = at_limit_q;

endmodule

// File: tb/tb_frequency_control_mc.sv
// Scoreboard bench: a saturating and a wrapping instance share clock and reset.
// Each expected step is queued with the cycle it must land on; every cycle the
// bench pops due entries and compares all outputs against its own model.
module tb_frequency_control_mc;

    localparam int NUM_CH     = 2;
    localparam int W          = 13;
    localparam int CH_W       = 1;
    localparam int NUM_SCALES = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic up_level = 1'b0, down_level = 1'b0, scale_pulse = 1'b0, ch_pulse = 1'b0;
    logic [NUM_CH*W-1:0] freq_out;
    logic [CH_W-1:0]     ch_sel_out;
    logic [2:0]          scale_out;
    logic                update_pulse, at_limit;

    logic wr_up = 1'b0, wr_down = 1'b0, wr_scale_p = 1'b0, wr_ch_p = 1'b0;
    logic [NUM_CH*W-1:0] wr_freq_out;
    logic [CH_W-1:0]     wr_ch_sel;
    logic [2:0]          wr_scale;
    logic                wr_update, wr_at_limit;

    always #5 clk = ~clk;

    frequency_control_mc #(
        .NUM_CH(NUM_CH), .FREQ_MIN(0), .FREQ_MAX(8191), .NUM_SCALES(NUM_SCALES),
        .REPEAT_DELAY(8), .REPEAT_PERIOD(3), .WRAP_EN(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .up_level(up_level), .down_level(down_level),
        .scale_pulse(scale_pulse), .ch_pulse(ch_pulse), .freq_out(freq_out),
        .ch_sel_out(ch_sel_out), .scale_out(scale_out), .update_pulse(update_pulse),
        .at_limit(at_limit)
    );

    frequency_control_mc #(
        .NUM_CH(NUM_CH), .FREQ_MIN(0), .FREQ_MAX(8191), .NUM_SCALES(NUM_SCALES),
        .REPEAT_DELAY(8), .REPEAT_PERIOD(3), .WRAP_EN(1'b1)
    ) dut_wrap (
        .clk(clk), .reset(reset), .up_level(wr_up), .down_level(wr_down),
        .scale_pulse(wr_scale_p), .ch_pulse(wr_ch_p), .freq_out(wr_freq_out),
        .ch_sel_out(wr_ch_sel), .scale_out(wr_scale), .update_pulse(wr_update),
        .at_limit(wr_at_limit)
    );

    typedef struct {
        bit wrap;
        int cyc;
        int ch;
        int freq;
        bit lim;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    int m_freq [NUM_CH];
    bit m_lim;
    int m_ch, m_scale;
    int n_freq [NUM_CH];
    bit n_lim;
    int n_ch, n_scale;

    task automatic push(input bit on_wrap, input int at_cyc, input int ch, input int f, input bit lim);
        sb_q.push_back('{wrap: on_wrap, cyc: at_cyc, ch: ch, freq: f, lim: lim});
    endtask

    // Advance one clock, update the reference model, compare every output.
    task automatic tick();
        bit rst, pm_sc, pm_ch, pw_sc, pw_ch;
        bit exp_m, exp_w;
        exp_t e;
        logic [NUM_CH*W-1:0] pack_m, pack_w;
        rst = reset; pm_sc = scale_pulse; pm_ch = ch_pulse; pw_sc = wr_scale_p; pw_ch = wr_ch_p;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin m_freq[c] = 0; n_freq[c] = 0; end
            m_lim = 0; m_ch = 0; m_scale = 0;
            n_lim = 0; n_ch = 0; n_scale = 0;
        end else begin
            if (pm_sc) m_scale = (m_scale + 1) % NUM_SCALES;
            if (pm_ch) m_ch = (m_ch + 1) % NUM_CH;
            if (pw_sc) n_scale = (n_scale + 1) % NUM_SCALES;
            if (pw_ch) n_ch = (n_ch + 1) % NUM_CH;
        end
        while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            e = sb_q.pop_front();
            vectors++; miscompares++;
            $display("FAIL stale_expect cyc=%0d entry_cyc=%0d ch=%0d freq=%0d", cyc, e.cyc, e.ch, e.freq);
        end
        exp_m = 0; exp_w = 0;
        if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
            e = sb_q.pop_front();
            if (e.wrap) begin n_freq[e.ch] = e.freq; n_lim = e.lim; exp_w = 1; end
            else        begin m_freq[e.ch] = e.freq; m_lim = e.lim; exp_m = 1; end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            pack_m[c*W +: W] = W'(m_freq[c]);
            pack_w[c*W +: W] = W'(n_freq[c]);
        end
        vectors++;
        if (update_pulse !== exp_m) begin miscompares++;
            $display("FAIL update_pulse cyc=%0d got=%b exp=%b", cyc, update_pulse, exp_m); end
        vectors++;
        if (freq_out !== pack_m) begin miscompares++;
            $display("FAIL freq_out cyc=%0d got ch1=%0d ch0=%0d exp ch1=%0d ch0=%0d", cyc,
                     freq_out[W +: W], freq_out[0 +: W], m_freq[1], m_freq[0]); end
        vectors++;
        if (at_limit !== m_lim) begin miscompares++;
            $display("FAIL at_limit cyc=%0d got=%b exp=%b", cyc, at_limit, m_lim); end
        vectors++;
        if (ch_sel_out !== CH_W'(m_ch)) begin miscompares++;
            $display("FAIL ch_sel_out cyc=%0d got=%0d exp=%0d", cyc, ch_sel_out, m_ch); end
        vectors++;
        if (scale_out !== 3'(m_scale)) begin miscompares++;
            $display("FAIL scale_out cyc=%0d got=%0d exp=%0d", cyc, scale_out, m_scale); end
        vectors++;
        if (wr_update !== exp_w) begin miscompares++;
            $display("FAIL wrap_update_pulse cyc=%0d got=%b exp=%b", cyc, wr_update, exp_w); end
        vectors++;
        if (wr_freq_out !== pack_w) begin miscompares++;
            $display("FAIL wrap_freq_out cyc=%0d got ch1=%0d ch0=%0d exp ch1=%0d ch0=%0d", cyc,
                     wr_freq_out[W +: W], wr_freq_out[0 +: W], n_freq[1], n_freq[0]); end
        vectors++;
        if (wr_at_limit !== n_lim) begin miscompares++;
            $display("FAIL wrap_at_limit cyc=%0d got=%b exp=%b", cyc, wr_at_limit, n_lim); end
        vectors++;
        if (wr_ch_sel !== CH_W'(n_ch)) begin miscompares++;
            $display("FAIL wrap_ch_sel cyc=%0d got=%0d exp=%0d", cyc, wr_ch_sel, n_ch); end
        vectors++;
        if (wr_scale !== 3'(n_scale)) begin miscompares++;
            $display("FAIL wrap_scale cyc=%0d got=%0d exp=%0d", cyc, wr_scale, n_scale); end
    endtask

    task automatic do_reset();
        up_level = 0; down_level = 0; scale_pulse = 0; ch_pulse = 0;
        wr_up = 0; wr_down = 0; wr_scale_p = 0; wr_ch_p = 0;
        reset = 1;
        repeat (2) tick();
        reset = 0;
        tick();
    endtask

    // One press-and-release in the given direction, expecting a single step.
    task automatic press(input bit on_wrap, input bit go_up, input int ch, input int f, input bit lim);
        push(on_wrap, cyc + 1, ch, f, lim);
        if (on_wrap) begin wr_up = go_up; wr_down = !go_up; end
        else         begin up_level = go_up; down_level = !go_up; end
        tick();
        up_level = 0; down_level = 0; wr_up = 0; wr_down = 0;
        tick();
    endtask

    task automatic pulse_scale(input bit on_wrap, input int n);
        repeat (n) begin
            if (on_wrap) wr_scale_p = 1; else scale_pulse = 1;
            tick();
            wr_scale_p = 0; scale_pulse = 0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (freq_out !== '0 || update_pulse !== 1'b0 || at_limit !== 1'b0) begin miscompares++;
            $display("FAIL reset_state got freq=%0h upd=%b lim=%b exp 0/0/0", freq_out, update_pulse, at_limit); end
    endtask

    task automatic test_basic();
        do_reset();
        press(0, 1, 0, 1, 0);
        repeat (3) tick();
    endtask

    task automatic test_autorepeat();
        int t0;
        do_reset();
        pulse_scale(0, 2);
        t0 = cyc + 1;
        push(0, t0, 0, 100, 0);
        push(0, t0 + 8, 0, 200, 0);
        push(0, t0 + 11, 0, 300, 0);
        push(0, t0 + 14, 0, 400, 0);
        push(0, t0 + 17, 0, 500, 0);
        up_level = 1;
        repeat (20) tick();
        up_level = 0;
        repeat (8) tick();
    endtask

    task automatic test_saturation();
        do_reset();
        pulse_scale(0, 3);
        for (int k = 1; k <= 8; k++) press(0, 1, 0, k * 1000, 0);
        pulse_scale(0, 3);
        press(0, 1, 0, 8100, 0);
        pulse_scale(0, 3);
        for (int k = 1; k <= 5; k++) press(0, 1, 0, 8100 + k * 10, 0);
        press(0, 1, 0, 8160, 0);
        pulse_scale(0, 1);
        press(0, 1, 0, 8191, 1);
        press(0, 1, 0, 8191, 1);
        press(0, 0, 0, 8091, 0);
        do_reset();
        pulse_scale(0, 2);
        for (int k = 1; k <= 5; k++) press(0, 1, 0, k * 100, 0);
        pulse_scale(0, 1);
        press(0, 0, 0, 0, 1);
        press(0, 0, 0, 0, 1);
        press(0, 1, 0, 1000, 0);
    endtask

    task automatic test_wrap();
        do_reset();
        press(1, 0, 0, 8191, 1);
        press(1, 1, 0, 0, 1);
        press(1, 1, 0, 1, 0);
        press(1, 0, 0, 0, 0);
    endtask

    task automatic test_conflicts();
        int t0;
        do_reset();
        up_level = 1; down_level = 1;
        repeat (12) tick();
        up_level = 0; down_level = 0;
        tick();
        push(0, cyc + 1, 0, 1, 0);
        up_level = 1;
        tick();
        down_level = 1;
        repeat (10) tick();
        up_level = 0;
        repeat (5) tick();
        down_level = 0;
        tick();
        // Channel change while repeating.
        do_reset();
        t0 = cyc + 1;
        push(0, t0, 0, 1, 0);
        push(0, t0 + 8, 0, 2, 0);
        push(0, t0 + 11, 0, 3, 0);
        up_level = 1;
        repeat (12) tick();
        ch_pulse = 1;
        tick();
        ch_pulse = 0;
        repeat (10) tick();
        up_level = 0;
        tick();
        press(0, 1, 1, 1, 0);
        // Scale pulse coincident with a press uses the old scale.
        do_reset();
        push(0, cyc + 1, 0, 1, 0);
        up_level = 1; scale_pulse = 1;
        tick();
        up_level = 0; scale_pulse = 0;
        tick();
        press(0, 1, 0, 11, 0);
    endtask

    task automatic test_reset_mid_hold();
        int t0;
        do_reset();
        pulse_scale(0, 1);
        ch_pulse = 1;
        tick();
        ch_pulse = 0;
        t0 = cyc + 1;
        push(0, t0, 1, 10, 0);
        up_level = 1;
        repeat (4) tick();
        reset = 1;
        repeat (2) tick();
        reset = 0;
        push(0, cyc + 1, 0, 1, 0);
        repeat (7) tick();
        up_level = 0;
        repeat (3) tick();
    endtask

    task automatic test_drain();
        vectors++;
        if (sb_q.size() != 0) begin miscompares++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", sb_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_autorepeat();
        test_saturation();
        test_wrap();
        test_conflicts();
        test_reset_mid_hold();
        test_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/frequency_control_mc.md
# frequency_control_mc

Multi-channel successor to the single-channel frequency store. It holds one frequency setpoint per lock-in reference channel and applies up/down steps of a selectable decade scale to the currently selected channel. Steps either saturate or wrap at the limits. Holding a button auto-repeats the step. The block sits between the debounced front-panel buttons and the NCO/reference generators, which consume `freq_out` directly.

## Interface
Parameters:
- `NUM_CH`, default 2: number of independent frequency channels, 1..8.
- `FREQ_MIN`, default 0: lower bound of every channel; also its reset value.
- `FREQ_MAX`, default 8191: upper bound of every channel; `W = $clog2(FREQ_MAX+1)`.
- `NUM_SCALES`, default 4: number of scales; scale `s` steps by `10^s`, with `s` in 0..NUM_SCALES-1 and NUM_SCALES ≤ 8.
- `REPEAT_DELAY`, default 25_000_000: cycles of continuous hold from the first step to the first auto-repeat step.
- `REPEAT_PERIOD`, default 5_000_000: cycles between later auto-repeat steps.
- `WRAP_EN`, default 0: 0 saturates at the bounds; 1 wraps MAX→MIN and MIN→MAX.

Ports:
- `clk`, input, 1: clock.
- `reset`, input, 1: synchronous, active-high.
- `up_level`, input, 1: debounced level; high while the up button is held.
- `down_level`, input, 1: debounced level; high while the down button is held.
- `scale_pulse`, input, 1: single-cycle pulse; advance the scale.
- `ch_pulse`, input, 1: single-cycle pulse; advance the selected channel.
- `freq_out`, output, NUM_CH*W: packed setpoints; channel c occupies `[c*W +: W]`.
- `ch_sel_out`, output, `$clog2(NUM_CH)` (min 1): selected channel.
- `scale_out`, output, 3: current scale index.
- `update_pulse`, output, 1: high for one cycle in the cycle a setpoint changes.
- `at_limit`, output, 1: high after a step that was clamped (saturate) or wrapped; cleared by the next normal step.

## Operation
Repeat FSM states are IDLE, HOLD and REPEAT, with a cycle counter `rpt_cnt` and a registered copy of each level (`up_d`, `down_d`).

- `dir_up = up_level & ~down_level`, `dir_dn = down_level & ~up_level`, `press = (dir_up|dir_dn) & ~(up_d|down_d)`.
- **IDLE**: on `press`, apply one step in the active direction, clear `rpt_cnt`, go to HOLD.
- **HOLD**: while the same direction is held, increment `rpt_cnt`. When `rpt_cnt == REPEAT_DELAY-1`, step, clear the counter and go to REPEAT.
- **REPEAT**: same as HOLD, but the compare value is `REPEAT_PERIOD-1`.
- **Exits from HOLD/REPEAT**: if the direction is released, both levels are high, or the direction changes, go to IDLE with no step. A reversed direction needs a fresh press.
- **Channel change**: `ch_pulse` advances `ch_sel_out` modulo NUM_CH and forces IDLE. A button still held then produces no steps until it is released and pressed again.
- **Scale change**: `scale_pulse` advances `scale_out` modulo NUM_SCALES. It does not affect the FSM. A step in the same cycle uses the old scale.
- **Step arithmetic**: use W+1-bit unsigned values (wider if `10^(NUM_SCALES-1) > FREQ_MAX`).
  - Up: if `f + step ≤ FREQ_MAX`, the result is the sum. Otherwise the result is FREQ_MAX (saturate) or FREQ_MIN (wrap), and `at_limit` is set.
  - Down: if `f ≥ FREQ_MIN + step`, the result is the difference. Otherwise the result is FREQ_MIN (saturate) or FREQ_MAX (wrap), and `at_limit` is set.
- **Pinned steps**: a step from a value already at the bound still counts as a step. It sets `at_limit` and pulses `update_pulse` even though the value is unchanged.
- Only the selected channel changes; all other channels hold their value.

## Timing
- **Reset values**: all channels FREQ_MIN, `ch_sel_out` 0, `scale_out` 0, `update_pulse` 0, `at_limit` 0, FSM in IDLE, `up_d`/`down_d` 0. Reset has priority over every input and aborts HOLD/REPEAT immediately.
- **Step latency**: if `press` is sampled at edge t0, the new `freq_out` and `update_pulse` are visible after t0.
- **Repeat schedule**: with the level held, repeat step k ≥ 1 lands at edge `t0 + REPEAT_DELAY + (k-1)*REPEAT_PERIOD`.
- **Selection latency**: `scale_out` and `ch_sel_out` update at the edge that samples their pulse.
- **Simultaneous pulses**: `ch_pulse` together with `press` means the step applies to the old channel, then the FSM goes to IDLE.

## Structure
- Package `freq_ctrl_pkg`:
  - repeat-state enum;
  - function `step_of(scale)` returning `10^scale` as a 32-bit constant;
  - localparam helper for W.
- One sub-module, `button_repeat`, contains the FSM, the counter and the edge detect. It outputs `step_req` and `step_dir`.
- The top level contains the channel register array, the scale/channel counters and the step arithmetic.

## Test plan
Bench parameters are REPEAT_DELAY=8 and REPEAT_PERIOD=3 unless noted.

- **Reset/basic**: after reset, one up press on ch0 at scale 0 → `freq_out[0]` = 1 and `update_pulse` is high for one cycle; ch1 stays 0.
- **Auto-repeat**: scale 2, hold up for 20 cycles from a press at edge t0 → steps at t0, t0+8, t0+11, t0+14, t0+17, so ch0 = 500. Release → no further steps.
- **Saturation** (WRAP_EN=0): ch0 = 8150, scale 1, one up → 8160; scale 2, one up → 8191 with `at_limit`=1; down at scale 3 from 500 → 0 with `at_limit`=1.
- **Wrap** (WRAP_EN=1): ch0 = 8191, scale 0, one up → 0 with `at_limit`=1; one more up → 1 with `at_limit`=0.
- **Conflicts**: both levels high → no step. `ch_pulse` while holding up in REPEAT → no further steps, ch1 unchanged, and a re-press steps ch1. `scale_pulse` in the same cycle as a press → the step uses the old scale.
- **Reset mid-HOLD**: assert reset at t0+4 → all outputs return to reset values, and no step occurs at t0+8 even if up stays high. After reset is released, a still-held level is treated as a new press.
